// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates trap entry, data-memory wait, branch
// redirect and load-use hazard into PC stall and stage-1/stage-2 enable/bubble controls.
module msrv32_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        dmem_req_in,
  input  logic        dmem_ready_in,
  input  logic        branch_taken_in,
  input  logic        trap_taken_in,
  input  logic        load_stage2_in,
  input  logic [4:0]  rd_addr_stage2_in,
  input  logic [4:0]  rs1_addr_dec_in,
  input  logic [4:0]  rs2_addr_dec_in,
  input  logic        rs1_used_in,
  input  logic        rs2_used_in,
  output logic        pc_stall_out,
  output logic        reg1_en_out,
  output logic        reg1_flush_out,
  output logic        reg2_en_out,
  output logic        reg2_flush_out,
  output logic        trap_ack_out,
  output logic        bus_error_out,
  output logic [1:0]  state_out,
  output logic [31:0] stall_cnt_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam logic [7:0] FLUSH_LOAD   = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load_use;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = load_stage2_in && (rd_addr_stage2_in != 5'd0) &&
                    ((rs1_used_in && (rs1_addr_dec_in == rd_addr_stage2_in)) ||
                     (rs2_used_in && (rs2_addr_dec_in == rd_addr_stage2_in)));

  assign state_out = state_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_FLUSH;
      cnt_q         <= FLUSH_LOAD;
      stall_cnt_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall_out && (stall_cnt_out != 32'hFFFF_FFFF))
        stall_cnt_out <= stall_cnt_out + 32'd1;
    end
  end

  always_comb begin
    pc_stall_out   = 1'b0;
    reg1_en_out    = 1'b1;
    reg2_en_out    = 1'b1;
    reg1_flush_out = 1'b0;
    reg2_flush_out = 1'b0;
    trap_ack_out   = 1'b0;
    bus_error_out  = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (trap_taken_in) begin
          trap_ack_out   = 1'b1;
          reg1_flush_out = 1'b1;
          reg2_flush_out = 1'b1;
          state_d        = ST_FLUSH;
          cnt_d          = FLUSH_LOAD;
        end else if (dmem_req_in && !dmem_ready_in) begin
          pc_stall_out = 1'b1;
          reg1_en_out  = 1'b0;
          reg2_en_out  = 1'b0;
          state_d      = ST_MEM_WAIT;
          cnt_d        = 8'd1;
        end else if (branch_taken_in) begin
          reg1_flush_out = 1'b1;
          reg2_flush_out = 1'b1;
        end else if (load_use) begin
          pc_stall_out   = 1'b1;
          reg1_en_out    = 1'b0;
          reg2_flush_out = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // ready on the timeout cycle takes precedence over the bus error
        if (dmem_ready_in) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          bus_error_out  = 1'b1;
          reg1_flush_out = 1'b1;
          reg2_flush_out = 1'b1;
          state_d        = ST_FLUSH;
          cnt_d          = FLUSH_LOAD;
        end else begin
          pc_stall_out = 1'b1;
          reg1_en_out  = 1'b0;
          reg2_en_out  = 1'b0;
          cnt_d        = cnt_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        reg1_flush_out = 1'b1;
        reg2_flush_out = 1'b1;
        if (cnt_q == 8'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase

    if (rst_in) begin
      pc_stall_out   = 1'b1;
      reg1_en_out    = 1'b0;
      reg2_en_out    = 1'b0;
      reg1_flush_out = 1'b1;
      reg2_flush_out = 1'b1;
      trap_ack_out   = 1'b0;
      bus_error_out  = 1'b0;
    end
  end

endmodule

// File: doc/msrv32_pipe_ctrl.md
Name: msrv32_pipe_ctrl

Overview:
- Pipeline sequencing controller for the msrv32 core.
- Drives hold (enable) and bubble (flush) for the stage-1 and stage-2 pipeline registers, and stall for the PC.
- Arbitrates between trap entry, data-memory wait, branch redirect and load-use hazard under a fixed priority.
- Sits beside the stage-2 register block; its outputs gate that register's capture on every clock edge.

Parameters:
- FLUSH_CYCLES, 2: cycles spent in FLUSH after trap acceptance, bus error or reset release; legal range 1..15.
- MEM_TIMEOUT, 16: MEM_WAIT cycles before bus error is declared; legal range 2..255.

Ports:
- clk_in  input  1  core clock
- rst_in  input  1  asynchronous, active-high reset
- dmem_req_in  input  1  stage-3 load/store issued this cycle
- dmem_ready_in  input  1  data memory completes this cycle
- branch_taken_in  input  1  taken branch/jump resolved in stage 2
- trap_taken_in  input  1  trap request; level, held by source until trap_ack_out
- load_stage2_in  input  1  instruction in stage 2 is a load
- rd_addr_stage2_in  input  5  destination of stage-2 instruction
- rs1_addr_dec_in  input  5  rs1 of decoding instruction
- rs2_addr_dec_in  input  5  rs2 of decoding instruction
- rs1_used_in  input  1  decoding instruction reads rs1
- rs2_used_in  input  1  decoding instruction reads rs2
- pc_stall_out  output  1  PC holds value
- reg1_en_out  output  1  stage-1 register captures
- reg1_flush_out  output  1  stage-1 register loads bubble
- reg2_en_out  output  1  stage-2 register captures
- reg2_flush_out  output  1  stage-2 register loads bubble (rf_wr_en, csr_wr_en cleared)
- trap_ack_out  output  1  one-cycle trap acceptance pulse
- bus_error_out  output  1  one-cycle memory timeout pulse
- state_out  output  2  current state
- stall_cnt_out  output  32  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk_in; rst_in is asynchronous and active-high.
- States (state_out encoding): RUN=0, MEM_WAIT=1, FLUSH=2. Code 3 is illegal: it drives RUN defaults and goes to RUN next.
- Internal 8-bit counter cnt.
- Control outputs are combinational from state and inputs. state, cnt and stall_cnt_out are registered.
- Flush overrides enable: a flushed register loads a bubble regardless of its en.
- While rst_in is high:
  - state=FLUSH, cnt=FLUSH_CYCLES-1, stall_cnt_out=0.
  - Outputs forced: pc_stall_out=1, reg1_en_out=0, reg2_en_out=0, reg1_flush_out=1, reg2_flush_out=1, trap_ack_out=0, bus_error_out=0.
- RUN defaults: pc_stall=0, reg1_en=1, reg2_en=1, flushes 0. Events are checked in priority order; the first match wins:
  1. trap_taken_in: trap_ack_out=1, reg1_flush=1, reg2_flush=1. Next FLUSH, cnt=FLUSH_CYCLES-1.
  2. dmem_req_in & !dmem_ready_in: pc_stall=1, reg1_en=0, reg2_en=0. Next MEM_WAIT, cnt=1.
  3. branch_taken_in: reg1_flush=1, reg2_flush=1. Stay RUN.
  4. Load-use hazard, defined as load_stage2_in & rd_addr_stage2_in!=0 & ((rs1_used_in & rs1_addr_dec_in==rd_addr_stage2_in) | (rs2_used_in & rs2_addr_dec_in==rd_addr_stage2_in)):
     - pc_stall=1, reg1_en=0, reg2_flush=1; one bubble per assertion.
     - rd=x0 never hazards.
- MEM_WAIT:
  - If dmem_ready_in: RUN defaults, next RUN, cnt=0.
  - Else if cnt==MEM_TIMEOUT-1: bus_error_out=1, both flushes=1, pc_stall=0. Next FLUSH, cnt=FLUSH_CYCLES-1.
  - Else: pc_stall=1, enables 0, cnt+1.
  - Ready arriving on the timeout cycle wins; no error is raised.
- FLUSH:
  - Outputs: pc_stall=0, enables 1, both flushes=1.
  - If cnt==0, next RUN; else cnt-1.
- trap_taken_in is not acknowledged in MEM_WAIT or FLUSH; the source holds it and it is accepted in the first RUN cycle.
- Simultaneous trap and memory wait in RUN: trap wins, and the pending access is abandoned by the flush.
- stall_cnt_out increments on each edge where pc_stall_out=1 and rst_in is low; it saturates at 32'hFFFF_FFFF.
- Reset asserted mid-MEM_WAIT or mid-FLUSH restarts cleanly in FLUSH with the reset values above.

Test Plan:
- Reset release, idle inputs -> state_out=2 with both flushes high for exactly 2 cycles, then state_out=0 with reg1_en_out=reg2_en_out=1; stall_cnt_out=0.
- In RUN: load_stage2_in=1, rd_addr_stage2_in=5, rs2_addr_dec_in=5, rs2_used_in=1 for one cycle -> pc_stall_out=1, reg1_en_out=0, reg2_flush_out=1 that cycle; stall_cnt_out=1 after. Repeat with rd=0 -> no stall.
- dmem_req_in=1 with dmem_ready_in low for 4 cycles, then high -> MEM_WAIT for 4 cycles, enables 0, release on the ready cycle; stall_cnt_out=4.
- dmem_ready_in held low forever after a request -> bus_error_out pulses once in the 16th stall cycle, followed by 2 FLUSH cycles, then RUN.
- trap_taken_in and branch_taken_in asserted together in RUN -> trap_ack_out=1 (single pulse), FLUSH for 2 cycles. Trap raised during MEM_WAIT -> ack delayed until the first RUN cycle.
- Force state to code 3 via reset-free injection, or assert rst_in in the middle of MEM_WAIT -> next state RUN (illegal code) or FLUSH (reset); outputs match the reset values while rst_in is high.
